scan_window_select: RTL
=======================

# scan_window_select

Parametrised per-revolution window selector for the ranging datapath. It sits between distance calculation and packet framing. On each `zero_flag` it latches a start offset, window length and decimation factor, then forwards the selected samples of the revolution with their output index. Out-of-range distances are replaced with an invalid code. Revolutions that end before their window is full are flagged.

## Interface
Parameters:
- `DATA_W`, 16, distance sample width
- `IDX_W`, 16, width of offset, length and index fields
- `MAX_WIN`, 1081, largest legal window length
- `DEC_W`, 4, decimation field width

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset, synchronous, active-high
- `zero_flag`  in  1  one-cycle pulse at the zero-angle mark
- `angle_offset`  in  IDX_W  samples to skip after zero mark
- `win_len`  in  IDX_W  samples to emit per revolution
- `decim`  in  DEC_W  keep 1 of every `decim` samples
- `min_dist`  in  DATA_W  minimum valid distance
- `max_dist`  in  DATA_W  maximum valid distance (see Configuration)
- `data_in_valid`  in  1  input sample strobe
- `data_in`  in  DATA_W  distance sample
- `cycle_enable`  out  1  high while in ENABLE
- `data_out_valid`  out  1  output sample strobe
- `data_out`  out  DATA_W  selected or clamped sample
- `data_out_idx`  out  IDX_W  0-based index within window
- `cycle_done`  out  1  pulse with last sample of a full window
- `cycle_short`  out  1  pulse when `zero_flag` cuts a window short

## Operation
- States: IDLE (after reset, waiting for first `zero_flag`), SKIP, ENABLE, HOLD (window complete, waiting for `zero_flag`).
- `zero_flag` in any state:
  - latches `angle_offset`, `win_len` and `decim`;
  - clears the input counter `k`, the decimation phase and the output counter;
  - enters SKIP, or enters ENABLE directly when the latched offset is 0.
- Sample indexing: an input sample accepted in the `zero_flag` cycle is index `k`=0. Each later `data_in_valid` increments `k`. `k` saturates at all-ones.
- SKIP → ENABLE once `k` reaches the offset. The sample with `k` == offset is the first candidate.
- In ENABLE, candidate samples are those with (`k` − offset) mod `decim` == 0. The modulo is implemented with a phase counter, not a divider. Each candidate is emitted.
- Emitted value:
  - `data_in` < `min_dist` → all-ones;
  - otherwise `data_in`.
- After `win_len` emissions: `cycle_done` pulses and the block enters HOLD. HOLD ignores input.
- `zero_flag` in SKIP or ENABLE (window incomplete): `cycle_short` pulses, then a new revolution starts as above. `zero_flag` in IDLE or HOLD produces no flag.
- Latched config sanitising:
  - `decim` 0 is treated as 1;
  - `win_len` 0 is treated as 1;
  - `win_len` > `MAX_WIN` is clamped to `MAX_WIN`.
- Live inputs are ignored between `zero_flag` pulses. `min_dist` and `max_dist` are sampled live.

## Timing
- All outputs are registered. Reset values: `cycle_enable`, `data_out_valid`, `cycle_done` and `cycle_short` are 0; `data_out` and `data_out_idx` are 0; state is IDLE.
- Latency: one cycle from `data_in_valid` to `data_out_valid`.
- `data_out` and `data_out_idx` hold their value when `data_out_valid` is 0.
- `cycle_done` is coincident with the final `data_out_valid`.
- `cycle_short` is asserted one cycle after the terminating `zero_flag`.
- `zero_flag` and `data_in_valid` in the same cycle: the flag takes priority, and the sample is treated as `k`=0 of the new revolution. If the old window was in ENABLE, that sample is not emitted under the old window.
- Back-to-back `zero_flag` pulses: each restarts the revolution. `cycle_short` is asserted only if the previous state was SKIP or ENABLE.
- `rst` mid-window: the next cycle shows all outputs at reset values; no `cycle_done` or `cycle_short` is produced.
- No backpressure. The downstream block must accept one sample per cycle.

## Configuration
- `SCAN_SEL_MAX_CLAMP_EN` defined: a sample with `data_in` > `max_dist` is also replaced by all-ones.
- `SCAN_SEL_MAX_CLAMP_EN` undefined: `max_dist` is ignored and left unconnected internally. Only the `min_dist` clamp applies.

## Structure
- Shared package `scan_pkg` holds:
  - state encoding constants (one-hot, 4 bits);
  - the all-ones invalid code as a function of `DATA_W`;
  - default `MAX_WIN` (1081) and window length (811).
- One sub-module, `scan_range_clamp`: registered min/max compare and substitute. It contains the `SCAN_SEL_MAX_CLAMP_EN` guard.

## Test plan
- `angle_offset`=135, `win_len`=811, `decim`=1, 1081 valid samples with value 500 → 811 outputs with `data_out_idx` 0..810. The first output follows input `k`=135. `cycle_done` is asserted with idx 810 and there is no `cycle_short`.
- `angle_offset`=0, `decim`=3, `win_len`=4, valid asserted in the `zero_flag` cycle → outputs come from `k`=0,3,6,9. `cycle_done` is asserted at `k`=9 output; HOLD then ignores `k`≥10.
- `min_dist`=20, inputs 19, 20, 0xFFFE → outputs 0xFFFF, 20, 0xFFFE. With the macro defined and `max_dist`=0x1000, the third output is 0xFFFF.
- `win_len`=811 but `zero_flag` arrives after 400 inputs with offset 0 → `cycle_short`=1 one cycle later, and the next output is `data_out_idx`=0 of the new revolution.
- `rst` asserted at output idx 300 → all outputs are 0 next cycle and state is IDLE. Inputs are ignored until `zero_flag`.
- `decim`=0, `win_len`=0 → behaves as 1/1: exactly one output, then `cycle_done`.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and constants for the per-revolution scan window selector.
package scan_pkg;

  // One-hot state encoding, also exported on the debug state port.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_SKIP   = 4'b0010,
    ST_ENABLE = 4'b0100,
    ST_HOLD   = 4'b1000
  } scan_state_t;

  localparam int SCAN_MAX_WIN_DEFAULT = 1081;
  localparam int SCAN_WIN_LEN_DEFAULT = 811;

  // Invalid-distance code: the low 'width' bits set, callers slice to their width.
  function automatic logic [63:0] invalid_code(input int width);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/scan_window_select_if.sv
// Sample-in / sample-out bus of the scan window selector.
interface scan_window_select_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 16
);
    // Valid-only streams: a beat transfers on every cycle its valid is high;
    // there is no ready, so the consumer must accept one beat per cycle.
    logic              data_in_valid;
    logic [DATA_W-1:0] data_in;
    logic              data_out_valid;
    logic [DATA_W-1:0] data_out;
    logic [IDX_W-1:0]  data_out_idx;
    logic              cycle_enable;
    logic              cycle_done;
    logic              cycle_short;

    modport slave (
        input  data_in_valid, data_in,
        output data_out_valid, data_out, data_out_idx,
               cycle_enable, cycle_done, cycle_short
    );

    modport master (
        output data_in_valid, data_in,
        input  data_out_valid, data_out, data_out_idx,
               cycle_enable, cycle_done, cycle_short
    );
endinterface

// File: rtl/scan_range_clamp.sv
// Registered range check: out-of-range samples become the all-ones code.
// Upper bound check only exists when SCAN_SEL_MAX_CLAMP_EN is defined.
module scan_range_clamp
    import scan_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] min_dist,
`ifdef SCAN_SEL_MAX_CLAMP_EN
    input  logic [DATA_W-1:0] max_dist,
`endif
    output logic [DATA_W-1:0] dout
);
    localparam logic [63:0]       INV_WIDE = invalid_code(DATA_W);
    localparam logic [DATA_W-1:0] INV      = INV_WIDE[DATA_W-1:0];

    logic below_min;
    logic above_max;

    assign below_min = din < min_dist;
`ifdef SCAN_SEL_MAX_CLAMP_EN
    assign above_max = din > max_dist;
`else
    assign above_max = 1'b0;
`endif

    // Holds its value between strobes so data_out is stable when not valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (en) begin
            dout <= (below_min || above_max) ? INV : din;
        end
    end
endmodule

// File: rtl/scan_window_select.sv
// Per-revolution window selector: skip, decimate and index samples after zero_flag.
// Optional SCAN_SEL_MAX_CLAMP_EN adds the max_dist clamp in scan_range_clamp.
module scan_window_select
    import scan_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int IDX_W   = 16,
    parameter int MAX_WIN = SCAN_MAX_WIN_DEFAULT,
    parameter int DEC_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               zero_flag,
    input  logic [IDX_W-1:0]   angle_offset,
    input  logic [IDX_W-1:0]   win_len,
    input  logic [DEC_W-1:0]   decim,
    input  logic [DATA_W-1:0]  min_dist,
    input  logic [DATA_W-1:0]  max_dist,
    scan_window_select_if.slave bus,
    output scan_state_t        dbg_state
);
    localparam logic [IDX_W-1:0] MAX_WIN_C = IDX_W'(MAX_WIN);
    localparam logic [IDX_W-1:0] K_SAT     = '1;

    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] off_q, len_q, k_q, k_d, cnt_q, cnt_d;
    logic [DEC_W-1:0] dec_q, phase_q, phase_d;
    logic [IDX_W-1:0] cfg_len;
    logic [DEC_W-1:0] cfg_dec;
    logic [IDX_W-1:0] eff_off, eff_len, eff_k, eff_cnt;
    logic [DEC_W-1:0] eff_dec, eff_phase;
    logic             active, take, in_win, emit, last, was_open;
    logic             valid_q, done_q, short_q;
    logic [IDX_W-1:0] idx_q;

    assign cfg_len  = (win_len == '0) ? IDX_W'(1) :
                      (win_len > MAX_WIN_C) ? MAX_WIN_C : win_len;
    assign cfg_dec  = (decim == '0) ? DEC_W'(1) : decim;
    assign was_open = (state_q == ST_SKIP) || (state_q == ST_ENABLE);

    // zero_flag overrides the latched context so its own sample is k=0 of the new revolution.
    always_comb begin
        eff_off   = off_q;
        eff_len   = len_q;
        eff_dec   = dec_q;
        eff_k     = k_q;
        eff_phase = phase_q;
        eff_cnt   = cnt_q;
        active    = was_open;
        if (zero_flag) begin
            eff_off   = angle_offset;
            eff_len   = cfg_len;
            eff_dec   = cfg_dec;
            eff_k     = '0;
            eff_phase = '0;
            eff_cnt   = '0;
            active    = 1'b1;
        end

        take   = active && bus.data_in_valid;
        in_win = eff_k >= eff_off;
        emit   = take && in_win && (eff_phase == '0);
        last   = emit && (eff_cnt == eff_len - IDX_W'(1));

        k_d = eff_k;
        if (take && (eff_k != K_SAT)) k_d = eff_k + IDX_W'(1);

        // Phase tracks (k - offset) mod decim without a divider.
        phase_d = eff_phase;
        if (take && in_win) begin
            phase_d = (eff_phase == eff_dec - DEC_W'(1)) ? '0 : eff_phase + DEC_W'(1);
        end

        cnt_d = emit ? eff_cnt + IDX_W'(1) : eff_cnt;

        state_d = state_q;
        if (active) begin
            if (last)                 state_d = ST_HOLD;
            else if (k_d >= eff_off)  state_d = ST_ENABLE;
            else                      state_d = ST_SKIP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            off_q   <= '0;
            len_q   <= IDX_W'(SCAN_WIN_LEN_DEFAULT);
            dec_q   <= DEC_W'(1);
            k_q     <= '0;
            phase_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (zero_flag) begin
                off_q <= angle_offset;
                len_q <= cfg_len;
                dec_q <= cfg_dec;
            end
            k_q     <= k_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            valid_q <= emit;
            if (emit) idx_q <= eff_cnt;
            done_q  <= last;
            short_q <= zero_flag && was_open;
        end
    end

    scan_range_clamp #(.DATA_W(DATA_W)) u_clamp (
        .clk      (clk),
        .rst      (rst),
        .en       (emit),
        .din      (bus.data_in),
        .min_dist (min_dist),
`ifdef SCAN_SEL_MAX_CLAMP_EN
        .max_dist (max_dist),
`endif
        .dout     (bus.data_out)
    );

`ifndef SCAN_SEL_MAX_CLAMP_EN
    logic unused_max_dist;
    assign unused_max_dist = ^max_dist;
`endif

    assign bus.data_out_valid = valid_q;
    assign bus.data_out_idx   = idx_q;
    assign bus.cycle_done     = done_q;
    assign bus.cycle_short    = short_q;
    assign bus.cycle_enable   = (state_q == ST_ENABLE);
    assign dbg_state          = state_q;
endmodule
